// File: rtl/encoder4x2_seq.sv
// encoder4x2_seq: captures a multi-hot snapshot of i0..i3 and streams the index of each set line
// in priority order over valid/ready; {s1,s0} is meant to drive a decoder2x4 directly.
module encoder4x2_seq #(
    parameter int HI_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    input  logic       load,
    input  logic       ready,
    output logic       s0,
    output logic       s1,
    output logic       valid,
    output logic       busy,
    output logic [2:0] count,
    output logic       none
);
    typedef enum logic {IDLE, SERVE} state_t;
    state_t state, next_state;
    logic [3:0] pend, req, served;
    logic [1:0] idx;
    assign req = {i3, i2, i1, i0};
    always_comb begin
        idx = HI_FIRST != 0
            ? (pend[3] ? 2'd3 : pend[2] ? 2'd2 : pend[1] ? 2'd1 : 2'd0)
            : (pend[0] ? 2'd0 : pend[1] ? 2'd1 : pend[2] ? 2'd2 : 2'd3);
        served = 4'b0001 << idx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= 4'b0;
            none  <= 1'b0;
        end else begin
            state <= next_state;
            none  <= state == IDLE && load && req == 4'b0;
            if (state == IDLE && load)
                pend <= req;
            else if (state == SERVE && ready)
                pend <= pend & ~served;
        end
    end
    // SERVE ends on the transfer that clears the last pending bit
    always_comb begin
        next_state = state;
        if (state == IDLE)
            next_state = load && req != 4'b0 ? SERVE : IDLE;
        else if (ready && (pend & ~served) == 4'b0)
            next_state = IDLE;
    end
    always_comb begin
        busy  = state == SERVE;
        valid = state == SERVE;
        {s1, s0} = state == SERVE ? idx : 2'b00;
        count = {2'b0, pend[0]} + {2'b0, pend[1]} + {2'b0, pend[2]} + {2'b0, pend[3]};
    end
endmodule

// File: tb/tb_encoder4x2_seq.sv
// tb_encoder4x2_seq: drives both priority orders in lockstep; a scoreboard holds the expected
// {count,code} stream of each instance and a decoder model accumulates the served lines.
module tb_encoder4x2_seq;
    logic clk = 0;
    logic rst = 1;
    logic i0 = 0, i1 = 0, i2 = 0, i3 = 0;
    logic load = 0, ready = 0;
    logic s0_h, s1_h, valid_h, busy_h, none_h;
    logic s0_l, s1_l, valid_l, busy_l, none_l;
    logic [2:0] count_h, count_l;
    logic [3:0] acc_h = 0, acc_l = 0;
    logic [4:0] exp_h[$];
    logic [4:0] exp_l[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    encoder4x2_seq #(.HI_FIRST(1)) dut_h (
        .clk(clk), .rst(rst), .i0(i0), .i1(i1), .i2(i2), .i3(i3), .load(load), .ready(ready),
        .s0(s0_h), .s1(s1_h), .valid(valid_h), .busy(busy_h), .count(count_h), .none(none_h)
    );
    encoder4x2_seq #(.HI_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .i0(i0), .i1(i1), .i2(i2), .i3(i3), .load(load), .ready(ready),
        .s0(s0_l), .s1(s1_l), .valid(valid_l), .busy(busy_l), .count(count_l), .none(none_l)
    );

    // Every accepted transfer pops the scoreboard and feeds the decoder model
    always @(negedge clk) begin
        logic [4:0] e;
        if (valid_h === 1'b1 && ready) begin
            checks++;
            if (exp_h.size() == 0) begin
                errors++;
                $display("FAIL xfer_hi: unexpected code %b count %0d", {s1_h, s0_h}, count_h);
            end else begin
                e = exp_h.pop_front();
                if ({count_h, s1_h, s0_h} !== e) begin
                    errors++;
                    $display("FAIL xfer_hi: got count %0d code %b, want count %0d code %b",
                             count_h, {s1_h, s0_h}, e[4:2], e[1:0]);
                end
            end
            acc_h = acc_h | (4'b0001 << {s1_h, s0_h});
        end
        if (valid_l === 1'b1 && ready) begin
            checks++;
            if (exp_l.size() == 0) begin
                errors++;
                $display("FAIL xfer_lo: unexpected code %b count %0d", {s1_l, s0_l}, count_l);
            end else begin
                e = exp_l.pop_front();
                if ({count_l, s1_l, s0_l} !== e) begin
                    errors++;
                    $display("FAIL xfer_lo: got count %0d code %b, want count %0d code %b",
                             count_l, {s1_l, s0_l}, e[4:2], e[1:0]);
                end
            end
            acc_l = acc_l | (4'b0001 << {s1_l, s0_l});
        end
    end

    task automatic push_exp(input logic [3:0] p);
        logic [2:0] c;
        c = 3'(p[0]) + 3'(p[1]) + 3'(p[2]) + 3'(p[3]);
        for (int b = 3; b >= 0; b--)
            if (p[b]) begin
                exp_h.push_back({c, 2'(b)});
                c--;
            end
        c = 3'(p[0]) + 3'(p[1]) + 3'(p[2]) + 3'(p[3]);
        for (int b = 0; b < 4; b++)
            if (p[b]) begin
                exp_l.push_back({c, 2'(b)});
                c--;
            end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] p);
        {i3, i2, i1, i0} = p;
        load = 1;
        push_exp(p);
        step();
        load = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_h || busy_l) && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (busy_h || busy_l) begin
            errors++;
            $display("FAIL wait_idle: busy_h %b busy_l %b after %0d cycles, want 0", busy_h, busy_l, n);
        end
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if ({valid_h, busy_h, count_h, valid_l, busy_l, count_l} !== 10'b0) begin
            errors++;
            $display("FAIL %s: valid %b/%b busy %b/%b count %0d/%0d, want all 0",
                     name, valid_h, valid_l, busy_h, busy_l, count_h, count_l);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        load = 1;
        {i3, i2, i1, i0} = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            step();
            @(negedge clk);
            checks++;
            if ({s1_h, s0_h, valid_h, busy_h, count_h, none_h, s1_l, s0_l, valid_l, busy_l, count_l, none_l} !== 16'b0) begin
                errors++;
                $display("FAIL reset: outputs hi %b%b v%b b%b c%0d n%b lo %b%b v%b b%b c%0d n%b, want all 0",
                         s1_h, s0_h, valid_h, busy_h, count_h, none_h, s1_l, s0_l, valid_l, busy_l, count_l, none_l);
            end
        end
        step();
        rst = 0;
        load = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            check_quiet("idle_after_reset");
        end
        step();
    endtask

    task automatic test_single();
        ready = 1;
        do_load(4'b0100);
        @(negedge clk);
        checks++;
        if ({valid_h, s1_h, s0_h, count_h, valid_l, s1_l, s0_l, count_l} !== {1'b1, 2'b10, 3'd1, 1'b1, 2'b10, 3'd1}) begin
            errors++;
            $display("FAIL single: hi v%b code %b c%0d lo v%b code %b c%0d, want v1 code 10 c1",
                     valid_h, {s1_h, s0_h}, count_h, valid_l, {s1_l, s0_l}, count_l);
        end
        step();
        @(negedge clk);
        check_quiet("single_done");
        step();
    endtask

    task automatic test_burst();
        ready = 1;
        do_load(4'b1111);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (!(valid_h === 1'b1 && valid_l === 1'b1)) begin
                errors++;
                $display("FAIL burst_valid: cycle %0d valid %b/%b, want 1", k, valid_h, valid_l);
            end
            step();
        end
        @(negedge clk);
        check_quiet("burst_done");
        step();
    endtask

    task automatic test_backpressure();
        ready = 0;
        do_load(4'b1010);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({valid_h, s1_h, s0_h, count_h, valid_l, s1_l, s0_l, count_l} !== {1'b1, 2'b11, 3'd2, 1'b1, 2'b01, 3'd2}) begin
                errors++;
                $display("FAIL stall: cycle %0d hi v%b code %b c%0d lo v%b code %b c%0d, want hi 11 c2 lo 01 c2",
                         k, valid_h, {s1_h, s0_h}, count_h, valid_l, {s1_l, s0_l}, count_l);
            end
            step();
        end
        ready = 1;
        wait_idle();
    endtask

    task automatic test_ignored_and_zero();
        ready = 0;
        do_load(4'b1000);
        {i3, i2, i1, i0} = 4'b0001;
        load = 1;
        step();
        load = 0;
        ready = 1;
        do_load_final_cycle();
        wait_idle();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_quiet("no_extra_code");
            step();
        end
        {i3, i2, i1, i0} = 4'b0000;
        load = 1;
        step();
        load = 0;
        @(negedge clk);
        checks++;
        if ({none_h, none_l, valid_h, valid_l} !== 4'b1100) begin
            errors++;
            $display("FAIL none_pulse: none %b/%b valid %b/%b, want none 1 valid 0", none_h, none_l, valid_h, valid_l);
        end
        step();
        @(negedge clk);
        checks++;
        if ({none_h, none_l, valid_h, valid_l} !== 4'b0000) begin
            errors++;
            $display("FAIL none_width: none %b/%b valid %b/%b, want 0", none_h, none_l, valid_h, valid_l);
        end
        step();
    endtask

    // Load asserted in the cycle of the final transfer must not be queued
    task automatic do_load_final_cycle();
        {i3, i2, i1, i0} = 4'b0001;
        load = 1;
        step();
        load = 0;
        @(negedge clk);
        check_quiet("load_at_final_xfer");
    endtask

    task automatic test_reset_mid();
        ready = 1;
        {i3, i2, i1, i0} = 4'b1111;
        load = 1;
        exp_h.push_back({3'd4, 2'b11});
        exp_l.push_back({3'd4, 2'b00});
        step();
        load = 0;
        step();
        rst = 1;
        ready = 0;
        step();
        @(negedge clk);
        check_quiet("reset_mid_serve");
        rst = 0;
        step();
        ready = 1;
        do_load(4'b0010);
        @(negedge clk);
        checks++;
        if ({valid_h, s1_h, s0_h, valid_l, s1_l, s0_l} !== 6'b101_101) begin
            errors++;
            $display("FAIL after_flush: v%b code %b / v%b code %b, want v1 code 01",
                     valid_h, {s1_h, s0_h}, valid_l, {s1_l, s0_l});
        end
        wait_idle();
    endtask

    task automatic test_loopback();
        for (int p = 0; p < 16; p++) begin
            acc_h = 0;
            acc_l = 0;
            ready = 1;
            do_load(4'(p));
            while (busy_h || busy_l) begin
                ready = 1'($urandom_range(0, 1));
                step();
                if ($time > 200000) break;
            end
            ready = 1;
            wait_idle();
            checks++;
            if (acc_h !== 4'(p) || acc_l !== 4'(p)) begin
                errors++;
                $display("FAIL loopback: pattern %b decoded hi %b lo %b", 4'(p), acc_h, acc_l);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_ignored_and_zero();
        test_reset_mid();
        test_loopback();
        checks++;
        if (exp_h.size() != 0 || exp_l.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expected codes never produced", exp_h.size(), exp_l.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
